multicycle_ctrl_unit: RTL and testbench

Multi-cycle control FSM that sequences the RV32I integer datapath (register file, ALU, PC register, PC+4 adder) for R-type and I-type ALU instructions. It fetches through a req/ack handshake with instruction memory and decodes opcode/funct3/funct7 into the datapath ALU encoding. It generates PC-enable, IR-load and register-file write strobes, and counts retired instructions. Illegal instructions and fetch timeouts send the FSM to a sticky trap.

---
 rtl/multicycle_ctrl_unit.sv | 186 ++++++++++++++++++
 tb/tb_multicycle_ctrl_unit.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl_unit.sv
// Multi-cycle RV32I control unit for R-type and I-type ALU instructions.
// Sequences FETCH/DECODE/EXECUTE/WRITEBACK and drops into a sticky TRAP
// on an illegal instruction or when instruction memory stops answering.
module multicycle_ctrl_unit #(
  parameter int unsigned CNT_W         = 32,
  parameter int unsigned FETCH_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             imemAck,
  input  logic [31:0]      instrCode,
  output logic             imemReq,
  output logic             irWe,
  output logic             pcEn,
  output logic             regFileWe,
  output logic             aluSrcB,
  output logic [3:0]       aluControl,
  output logic             trap,
  output logic [1:0]       trapCause,
  output logic [CNT_W-1:0] retiredCnt
);

  localparam int unsigned TO_W = 8;

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;
  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_SLL  = 4'd4;
  localparam logic [3:0] ALU_SRL  = 4'd5;
  localparam logic [3:0] ALU_SRA  = 4'd6;
  localparam logic [3:0] ALU_SLT  = 4'd7;
  localparam logic [3:0] ALU_SLTU = 4'd8;
  localparam logic [3:0] ALU_XOR  = 4'd9;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(FETCH_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_WRITEBACK,
    S_TRAP
  } state_t;

  state_t          state;
  logic [31:0]     ir;
  logic [TO_W-1:0] to_cnt;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       f7_zero;
  logic       f7_alt;

  logic [3:0] dec_ctrl;
  logic       dec_srcb;
  logic       dec_illegal;

  // Register indices and low immediate bits do not steer control.
  logic unused_ir_bits;
  assign unused_ir_bits = ^{ir[24:15], ir[11:7]};

  assign opcode  = ir[6:0];
  assign funct3  = ir[14:12];
  assign funct7  = ir[31:25];
  assign f7_zero = (funct7 == F7_ZERO);
  assign f7_alt  = (funct7 == F7_ALT);

  // Instruction decode into ALU op, operand-B select and legality.
  always_comb begin
    dec_ctrl    = ALU_ADD;
    dec_srcb    = 1'b0;
    dec_illegal = 1'b0;
    if (opcode == OP_R) begin
      dec_srcb = 1'b0;
      case (funct3)
        3'b000: begin
          if (f7_zero)     dec_ctrl = ALU_ADD;
          else if (f7_alt) dec_ctrl = ALU_SUB;
          else             dec_illegal = 1'b1;
        end
        3'b001: begin dec_ctrl = ALU_SLL;  dec_illegal = !f7_zero; end
        3'b010: begin dec_ctrl = ALU_SLT;  dec_illegal = !f7_zero; end
        3'b011: begin dec_ctrl = ALU_SLTU; dec_illegal = !f7_zero; end
        3'b100: begin dec_ctrl = ALU_XOR;  dec_illegal = !f7_zero; end
        3'b101: begin
          if (f7_zero)     dec_ctrl = ALU_SRL;
          else if (f7_alt) dec_ctrl = ALU_SRA;
          else             dec_illegal = 1'b1;
        end
        3'b110: begin dec_ctrl = ALU_OR;   dec_illegal = !f7_zero; end
        default: begin dec_ctrl = ALU_AND; dec_illegal = !f7_zero; end
      endcase
    end else if (opcode == OP_I) begin
      dec_srcb = 1'b1;
      case (funct3)
        3'b000: dec_ctrl = ALU_ADD;
        3'b001: begin dec_ctrl = ALU_SLL; dec_illegal = !f7_zero; end
        3'b010: dec_ctrl = ALU_SLT;
        3'b011: dec_ctrl = ALU_SLTU;
        3'b100: dec_ctrl = ALU_XOR;
        3'b101: begin
          if (f7_zero)     dec_ctrl = ALU_SRL;
          else if (f7_alt) dec_ctrl = ALU_SRA;
          else             dec_illegal = 1'b1;
        end
        3'b110: dec_ctrl = ALU_OR;
        default: dec_ctrl = ALU_AND;
      endcase
    end else begin
      dec_illegal = 1'b1;
    end
  end

  // Strobes follow the current state; reset forces them low immediately.
  assign imemReq   = !rst && (state == S_FETCH);
  assign irWe      = !rst && (state == S_FETCH) && imemAck;
  assign pcEn      = !rst && (state == S_WRITEBACK);
  assign regFileWe = !rst && (state == S_WRITEBACK);

  // Control sequencer with registered ALU controls, trap status and retire count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_FETCH;
      ir         <= 32'h0;
      to_cnt     <= '0;
      aluControl <= ALU_ADD;
      aluSrcB    <= 1'b0;
      trap       <= 1'b0;
      trapCause  <= CAUSE_NONE;
      retiredCnt <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          if (imemAck) begin
            ir     <= instrCode;
            to_cnt <= '0;
            state  <= S_DECODE;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
            if (to_cnt == TO_LAST) begin
              state     <= S_TRAP;
              trap      <= 1'b1;
              trapCause <= CAUSE_TIMEOUT;
            end
          end
        end
        S_DECODE: begin
          if (dec_illegal) begin
            state     <= S_TRAP;
            trap      <= 1'b1;
            trapCause <= CAUSE_ILLEGAL;
          end else begin
            aluControl <= dec_ctrl;
            aluSrcB    <= dec_srcb;
            state      <= S_EXECUTE;
          end
        end
        S_EXECUTE: begin
          state <= S_WRITEBACK;
        end
        S_WRITEBACK: begin
          retiredCnt <= retiredCnt + CNT_W'(1);
          state      <= S_FETCH;
        end
        S_TRAP: begin
          state <= S_TRAP;
        end
        default: begin
          state <= S_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl_unit.sv
// Directed bench for multicycle_ctrl_unit: decode sweep, fetch waits,
// traps, reset behaviour and retire-counter wrap on a narrow instance.
module tb_multicycle_ctrl_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imemAck = 1'b0;
  logic [31:0] instrCode = 32'h0;

  logic        imemReq, irWe, pcEn, regFileWe, aluSrcB, trap;
  logic [3:0]  aluControl;
  logic [1:0]  trapCause;
  logic [31:0] retiredCnt;

  logic        imemReq4, irWe4, pcEn4, regFileWe4, aluSrcB4, trap4;
  logic [3:0]  aluControl4;
  logic [1:0]  trapCause4;
  logic [3:0]  retiredCnt4;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] exp_cnt = 32'h0;

  logic [31:0] r_code [10] = '{32'h002081B3, 32'h402081B3, 32'h002091B3, 32'h0020A1B3,
                               32'h0020B1B3, 32'h0020C1B3, 32'h0020D1B3, 32'h4020D1B3,
                               32'h0020E1B3, 32'h0020F1B3};
  logic [3:0]  r_ctrl [10] = '{4'd0, 4'd1, 4'd4, 4'd7, 4'd8, 4'd9, 4'd5, 4'd6, 4'd3, 4'd2};

  multicycle_ctrl_unit #(.CNT_W(32), .FETCH_TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .imemAck(imemAck), .instrCode(instrCode),
    .imemReq(imemReq), .irWe(irWe), .pcEn(pcEn), .regFileWe(regFileWe),
    .aluSrcB(aluSrcB), .aluControl(aluControl), .trap(trap),
    .trapCause(trapCause), .retiredCnt(retiredCnt)
  );

  multicycle_ctrl_unit #(.CNT_W(4), .FETCH_TIMEOUT(15)) dut4 (
    .clk(clk), .rst(rst), .imemAck(imemAck), .instrCode(instrCode),
    .imemReq(imemReq4), .irWe(irWe4), .pcEn(pcEn4), .regFileWe(regFileWe4),
    .aluSrcB(aluSrcB4), .aluControl(aluControl4), .trap(trap4),
    .trapCause(trapCause4), .retiredCnt(retiredCnt4)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input logic [31:0] code, input logic [3:0] ctrl,
                           input logic srcb, input int waits);
    for (int i = 0; i < waits; i++) begin
      imemAck = 1'b0;
      instrCode = 32'hDEADBEEF;
      #1;
      check("wait_req", 32'(imemReq), 32'd1);
      check("wait_irwe", 32'(irWe), 32'd0);
      check("wait_pcen", 32'(pcEn), 32'd0);
      step();
    end
    imemAck = 1'b1;
    instrCode = code;
    #1;
    check("fetch_irwe", 32'(irWe), 32'd1);
    check("fetch_wb", 32'(regFileWe), 32'd0);
    step();
    instrCode = 32'h0;
    #1;
    check("decode_irwe", 32'(irWe), 32'd0);
    check("decode_req", 32'(imemReq), 32'd0);
    step();
    check("exec_ctrl", 32'(aluControl), 32'(ctrl));
    check("exec_srcb", 32'(aluSrcB), 32'(srcb));
    check("exec_strobes", 32'({irWe, pcEn, regFileWe}), 32'd0);
    step();
    check("wb_strobes", 32'({irWe, pcEn, regFileWe}), 32'd3);
    check("wb_ctrl", 32'(aluControl), 32'(ctrl));
    exp_cnt++;
    step();
    check("retired", retiredCnt, exp_cnt);
    check("next_fetch_ctrl", 32'(aluControl), 32'(ctrl));
    imemAck = 1'b0;
  endtask

  task automatic trap_instr(input logic [31:0] code);
    imemAck = 1'b1;
    instrCode = code;
    step();
    step();
    check("trap_flag", 32'(trap), 32'd1);
    check("trap_cause", 32'(trapCause), 32'd1);
    check("trap_retired", retiredCnt, exp_cnt);
    for (int i = 0; i < 3; i++) begin
      check("trap_strobes", 32'({imemReq, irWe, pcEn, regFileWe}), 32'd0);
      step();
    end
    imemAck = 1'b0;
  endtask

  task automatic do_reset();
    #1;
    rst = 1'b1;
    #1;
    check("rst_trap", 32'(trap), 32'd0);
    check("rst_cause", 32'(trapCause), 32'd0);
    check("rst_retired", retiredCnt, 32'd0);
    check("rst_req", 32'(imemReq), 32'd0);
    step();
    rst = 1'b0;
    exp_cnt = 32'h0;
    #1;
    check("post_rst_req", 32'(imemReq), 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    #12;
    check("reset_strobes", 32'({imemReq, irWe, pcEn, regFileWe}), 32'd0);
    check("reset_ctrl", 32'(aluControl), 32'd0);
    check("reset_srcb", 32'(aluSrcB), 32'd0);
    check("reset_trap", 32'({trap, trapCause}), 32'd0);
    check("reset_retired", retiredCnt, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("first_fetch_req", 32'(imemReq), 32'd1);

    // Back-to-back adds, then the full R-type sweep.
    for (int i = 0; i < 3; i++) run_instr(32'h002081B3, 4'd0, 1'b0, 0);
    check("three_adds", retiredCnt, 32'd3);
    for (int i = 0; i < 10; i++) run_instr(r_code[i], r_ctrl[i], 1'b0, 0);

    // I-type forms.
    run_instr(32'hFFF08193, 4'd0, 1'b1, 0);
    run_instr(32'h4030D193, 4'd6, 1'b1, 0);
    run_instr(32'hFFF0F193, 4'd2, 1'b1, 0);

    // Fetch stalls of three cycles, then a bad SRLI shift encoding.
    run_instr(32'h002081B3, 4'd0, 1'b0, 3);
    trap_instr(32'h0200D193);
    do_reset();

    // Memory never answers: timeout trap after fifteen fetch cycles.
    imemAck = 1'b0;
    for (int i = 0; i < 15; i++) begin
      check("to_req", 32'(imemReq), 32'd1);
      check("to_trap", 32'(trap), 32'd0);
      step();
    end
    check("to_flag", 32'(trap), 32'd1);
    check("to_cause", 32'(trapCause), 32'd2);
    imemAck = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("to_strobes", 32'({imemReq, irWe, pcEn, regFileWe}), 32'd0);
      step();
    end
    imemAck = 1'b0;
    do_reset();

    // Illegal all-zero opcode after one good instruction.
    run_instr(32'h002081B3, 4'd0, 1'b0, 0);
    trap_instr(32'h00000000);
    check("illegal_retired", retiredCnt, 32'd1);
    do_reset();

    // Reset arriving during EXECUTE aborts without a writeback.
    imemAck = 1'b1;
    instrCode = 32'h402081B3;
    step();
    step();
    #1;
    rst = 1'b1;
    #1;
    check("abort_strobes", 32'({pcEn, regFileWe}), 32'd0);
    step();
    check("abort_wb_slot", 32'({pcEn, regFileWe}), 32'd0);
    check("abort_retired", retiredCnt, 32'd0);
    step();
    rst = 1'b0;
    imemAck = 1'b0;
    exp_cnt = 32'h0;
    #1;
    check("abort_refetch", 32'(imemReq), 32'd1);
    run_instr(32'h002081B3, 4'd0, 1'b0, 0);

    // Sixteen instructions wrap the 4-bit counter back to zero.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      run_instr(32'h0020C1B3, 4'd9, 1'b0, 0);
      if (i == 14) check("cnt4_at15", 32'(retiredCnt4), 32'd15);
    end
    check("cnt4_wrap", 32'(retiredCnt4), 32'd0);
    check("cnt32_16", retiredCnt, 32'd16);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
